reset_sequencer: RTL

- Consumes the de-glitched pad reset and releases the chip's reset domains in a fixed, timed order: core, then peripheral, then user.
- Release is gated on PLL lock. Loss of lock, or a software reset request, re-runs the sequence.
- Sits directly downstream of the pad-reset / POR generation stage and drives the per-domain active-low resets.

---
 rtl/rstseq_pkg.sv | 9 +
 rtl/rstseq_sync.sv | 15 +
 rtl/reset_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/rstseq_pkg.sv
// rstseq_pkg: state encoding, counter type and default timing constants shared by reset_sequencer.
package rstseq_pkg;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STAGE_DLY = 16;
  localparam int DEF_LOCK_TMO = 200;
  localparam int DEF_CNT_W = 8;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, DLY_CORE, DLY_PERIPH, DLY_USER, RUN, SOFT} state_t;
endpackage

// File: rtl/rstseq_sync.sv
// rstseq_sync: N-flop synchronizer with asynchronous active-low clear.
module rstseq_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) ff <= '0;
    else ff <= {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases core, periph, user resets in timed order once the PLL is locked.
// RSTSEQ_LOCK_TMO_EN adds a lock-wait timeout with a sticky lock_timeout flag.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LOCK_TMO = DEF_LOCK_TMO
) (
  input  logic clk,
  input  logic rst_pad,
  input  logic pll_lock,
  input  logic soft_rst_req,
  output logic core_rstb,
  output logic periph_rstb,
  output logic user_rstb,
  output logic seq_done,
  output logic soft_rst_ack,
  output logic lock_timeout
);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
  state_t state;
  logic [CNT_W-1:0] cnt, wait_cnt;
  logic rst_sync, lock_s, lock_ok, tmo_hit;
  if (SYNC_STAGES < 2 || STAGE_DLY < 1 || 2 ** CNT_W <= STAGE_DLY || 2 ** CNT_W <= LOCK_TMO) begin : g_bad_params
    $error("reset_sequencer: invalid SYNC_STAGES/STAGE_DLY/CNT_W/LOCK_TMO");
  end
  rstseq_sync #(.N(SYNC_STAGES)) u_rst_sync (.clk(clk), .clr_n(rst_pad), .d(1'b1), .q(rst_sync));
  rstseq_sync #(.N(SYNC_STAGES)) u_lock_sync (.clk(clk), .clr_n(rst_pad), .d(pll_lock), .q(lock_s));
`ifdef RSTSEQ_LOCK_TMO_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TMO - 1);
  assign tmo_hit = cnt == TMO_LAST;
  assign wait_cnt = cnt + 1'b1;
  assign lock_ok = lock_s | lock_timeout;
  always_ff @(posedge clk or negedge rst_pad)
    if (!rst_pad) lock_timeout <= 1'b0;
    else if (state == WAIT_LOCK && !lock_s && tmo_hit) lock_timeout <= 1'b1;
`else
  assign tmo_hit = 1'b0;
  assign wait_cnt = '0;
  assign lock_ok = lock_s;
  assign lock_timeout = 1'b0;
`endif
  // cnt falls back to 0 on every cycle that does not explicitly advance it
  always_ff @(posedge clk or negedge rst_pad)
    if (!rst_pad) begin
      state <= IDLE;
      cnt <= '0;
      {core_rstb, periph_rstb, user_rstb, seq_done, soft_rst_ack} <= '0;
    end else begin
      soft_rst_ack <= 1'b0;
      cnt <= '0;
      case (state)
        IDLE: if (rst_sync) state <= WAIT_LOCK;
        WAIT_LOCK:
          if (lock_s || tmo_hit) state <= DLY_CORE;
          else cnt <= wait_cnt;
        DLY_CORE, DLY_PERIPH, DLY_USER:
          if (!lock_ok) begin
            {core_rstb, periph_rstb, user_rstb} <= '0;
            state <= WAIT_LOCK;
          end else if (cnt != DLY_LAST) cnt <= cnt + 1'b1;
          else begin
            core_rstb <= 1'b1;
            periph_rstb <= periph_rstb | (state != DLY_CORE);
            user_rstb <= state == DLY_USER;
            seq_done <= state == DLY_USER;
            state <= state == DLY_CORE ? DLY_PERIPH : state == DLY_PERIPH ? DLY_USER : RUN;
          end
        RUN:
          if (!lock_ok) begin
            {core_rstb, periph_rstb, user_rstb, seq_done} <= '0;
            state <= WAIT_LOCK;
          end else if (soft_rst_req) begin
            {user_rstb, seq_done} <= '0;
            state <= SOFT;
          end
        SOFT:
          if (cnt == '0) begin
            periph_rstb <= 1'b0;
            cnt <= cnt + 1'b1;
          end else begin
            core_rstb <= 1'b0;
            soft_rst_ack <= 1'b1;
            state <= WAIT_LOCK;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
